// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: control, stimulus and result signals between a sweeper and its user
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic       f_in;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] table_out;
    logic [3:0] mismatch_count;
    modport master (
        output start, abort, f_in,
        input  a, b, c, busy, done, pass, table_out, mismatch_count
    );
    modport slave (
        input  start, abort, f_in,
        output a, b, c, busy, done, pass, table_out, mismatch_count
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives a 3-input function through all 8 vectors, captures its
// truth table and compares it against EXPECTED.
module truth_table_sweeper #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXPECTED      = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] abc_q, abc_d;
    logic [7:0] table_q, table_d;
    logic [3:0] mm_q, mm_d;
    logic       pass_q, pass_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            table_q <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            table_q <= table_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        table_d = table_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        // abort outranks the SAMPLE capture and clears all results
        if (bus.abort && (state_q == SETTLE || state_q == SAMPLE)) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            abc_d   = '0;
            table_d = '0;
            mm_d    = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_d = SETTLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    abc_d   = '0;
                    table_d = '0;
                    mm_d    = '0;
                    pass_d  = 1'b0;
                end
                SETTLE: begin
                    state_d = (cnt_q == 4'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
                    cnt_d   = cnt_q + 4'd1;
                end
                SAMPLE: begin
                    table_d[idx_q] = bus.f_in;
                    mm_d           = mm_q + 4'(bus.f_in != EXPECTED[idx_q]);
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                        pass_d  = (mm_d == 4'd0);
                        done_d  = 1'b1;
                    end else begin
                        state_d = SETTLE;
                        idx_d   = idx_q + 3'd1;
                        abc_d   = idx_q + 3'd1;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    end

    assign {bus.a, bus.b, bus.c} = abc_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.pass              = pass_q;
    assign bus.table_out         = table_q;
    assign bus.mismatch_count    = mm_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps of a parity DUT (settle 2) and an AND DUT (settle 1)
module tb_truth_table_sweeper;
    logic clk;
    logic rst_n;
    logic stuck;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   e;

    truth_table_sweeper_if i0 ();
    truth_table_sweeper_if i1 ();

    assign i0.f_in = stuck ? 1'b0 : (i0.a ^ i0.b ^ i0.c);
    assign i1.f_in = i1.a & i1.b & i1.c;

    truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(8'h96)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'h80)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // p1/p2: extra start edges, ab_at: abort edge, rs_at: async reset after this edge (-1 = none)
    task automatic sweep0(input int p1, input int p2, input int ab_at, input int rs_at, output int edges);
        edges = -1;
        @(negedge clk);
        i0.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_e0", 32'(i0.busy), 1);
            if (k == 4) begin
                chk("abc_e4", 32'({i0.a, i0.b, i0.c}), 1);
                chk("busy_e4", 32'(i0.busy), 1);
            end
            if (k == 9 && ab_at == 10) chk("tbl_pre_abort", 32'(i0.table_out), 32'h06);
            if (k == ab_at) begin
                chk("abort_busy", 32'(i0.busy), 0);
                chk("abort_abc", 32'({i0.a, i0.b, i0.c}), 0);
                chk("abort_tbl", 32'(i0.table_out), 0);
                chk("abort_mm", 32'(i0.mismatch_count), 0);
            end
            if (i0.done) begin
                edges = k;
                break;
            end
            i0.start = (k + 1 == p1) || (k + 1 == p2);
            i0.abort = (k + 1 == ab_at);
            if (k == rs_at) begin
                chk("tbl_pre_rst", 32'(i0.table_out), 32'h16);
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy", 32'(i0.busy), 0);
                chk("rst_abc", 32'({i0.a, i0.b, i0.c}), 0);
                chk("rst_tbl", 32'(i0.table_out), 0);
                #1 rst_n = 1'b1;
            end
        end
        i0.start = 1'b0;
        i0.abort = 1'b0;
    endtask

    task automatic sweep1(output int edges);
        edges = -1;
        @(negedge clk);
        i1.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            i1.start = 1'b0;
            if (i1.done) begin
                edges = k;
                break;
            end
        end
        i1.start = 1'b0;
    endtask

    task automatic expect_good0(input string tag, input int edges);
        chk({tag, "_edges"}, 32'(edges), 24);
        chk({tag, "_tbl"}, 32'(i0.table_out), 32'h96);
        chk({tag, "_mm"}, 32'(i0.mismatch_count), 0);
        chk({tag, "_pass"}, 32'(i0.pass), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        stuck = 1'b0;
        i0.start = 1'b0; i0.abort = 1'b0;
        i1.start = 1'b0; i1.abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy0", 32'(i0.busy), 0);
        chk("rst_done0", 32'(i0.done), 0);
        chk("rst_pass0", 32'(i0.pass), 0);
        chk("rst_tbl0", 32'(i0.table_out), 0);
        chk("rst_mm0", 32'(i0.mismatch_count), 0);
        chk("rst_abc0", 32'({i0.a, i0.b, i0.c}), 0);
        chk("rst_tbl1", 32'(i1.table_out), 0);
        rst_n = 1'b1;

        sweep0(-1, -1, -1, -1, e);
        expect_good0("parity", e);
        @(negedge clk);
        chk("done_one_cycle", 32'(i0.done), 0);
        chk("pass_held", 32'(i0.pass), 1);
        chk("idle_busy", 32'(i0.busy), 0);

        stuck = 1'b1;
        sweep0(-1, -1, -1, -1, e);
        chk("stuck_edges", 32'(e), 24);
        chk("stuck_tbl", 32'(i0.table_out), 32'h00);
        chk("stuck_mm", 32'(i0.mismatch_count), 4);
        chk("stuck_pass", 32'(i0.pass), 0);
        stuck = 1'b0;

        sweep0(-1, -1, 10, -1, e);
        chk("abort_no_done", 32'(e), 32'hffffffff);
        sweep0(-1, -1, -1, -1, e);
        expect_good0("after_abort", e);

        sweep0(5, 10, -1, -1, e);
        expect_good0("busy_start", e);

        sweep0(-1, -1, -1, 15, e);
        chk("rst_no_done", 32'(e), 32'hffffffff);
        sweep0(-1, -1, -1, -1, e);
        expect_good0("after_rst", e);

        sweep1(e);
        chk("and_edges", 32'(e), 16);
        chk("and_tbl", 32'(i1.table_out), 32'h80);
        chk("and_mm", 32'(i1.mismatch_count), 0);
        chk("and_pass", 32'(i1.pass), 1);
        sweep1(e);
        chk("and2_edges", 32'(e), 16);
        chk("and2_tbl", 32'(i1.table_out), 32'h80);
        chk("and2_pass", 32'(i1.pass), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that drives a 3-input combinational function block (a, b, c -> out) through all 8 input combinations in ascending order.
- After a programmable settle time per vector, samples the block's output and builds an 8-bit captured truth table.
- Compares the capture against an expected table and reports pass/fail.
- Sits beside function_h-style blocks as an on-chip self-check, replacing the hand-written vector sweep.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range 1..15.
- EXPECTED, 8'h00, expected truth table; bit i = required out for {a,b,c} = i (a is MSB).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; accepted only in IDLE
- abort  input  1  synchronous abort of a running sweep
- f_in  input  1  output of the function under test
- a  output  1  stimulus MSB to the function under test
- b  output  1  stimulus middle bit
- c  output  1  stimulus LSB
- busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE)
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  high when the last completed sweep matched EXPECTED
- table_out  output  8  captured truth table; bit i = f_in sampled for vector i
- mismatch_count  output  4  number of bits where table_out differs from EXPECTED (0..8)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE
  - a = b = c = 0
  - busy = 0, done = 0, pass = 0
  - table_out = 8'h00, mismatch_count = 0
  - internal index = 0, settle counter = 0
- States are IDLE, SETTLE, SAMPLE and DONE. All outputs are registered.
- IDLE:
  - start=1 at a clock edge: index <= 0, {a,b,c} <= 3'b000, table_out <= 0, mismatch_count <= 0, pass <= 0, settle counter <= 0; go to SETTLE.
  - start=0: hold all outputs; results of the last sweep remain visible.
- SETTLE:
  - {a,b,c} is held at index; the counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (exactly 1 cycle):
  - table_out[index] <= f_in.
  - If f_in != EXPECTED[index], mismatch_count increments.
  - index < 7: index increments, {a,b,c} <= index+1, counter cleared; go to SETTLE.
  - index = 7: {a,b,c} stays 3'b111; go to DONE.
- DONE (1 cycle):
  - done = 1, and pass = (final mismatch_count == 0). pass and done are valid in the same cycle.
  - Then go to IDLE. pass holds until the next accepted start.
- busy = 1 in SETTLE and SAMPLE, 0 in IDLE and DONE.
- Latency: done is high in the cycle following clock edge number 8*(SETTLE_CYCLES+1), counting the start-accepting edge as edge 0.
- Boundary conditions:
  - start while busy or in DONE is ignored, with no effect on index or results.
  - abort=1 in SETTLE or SAMPLE: next state is IDLE, {a,b,c} <= 000, table_out and mismatch_count are cleared, pass = 0, no done pulse. abort in IDLE or DONE is ignored.
  - abort and start asserted in the same IDLE cycle: start wins, since abort is ignored in IDLE.
  - abort has priority over the SAMPLE capture in the same cycle.
  - rst_n low at any time, including mid-sweep, forces all reset values immediately (asynchronous), with no done pulse. Operation resumes in IDLE after release.
  - mismatch_count saturation is unnecessary; the maximum is 8 and fits in 4 bits.
  - f_in is sampled only in SAMPLE; changes at any other time are ignored.

Test Plan:
- Parity match: EXPECTED=8'h96, SETTLE_CYCLES=2, f_in=a^b^c, start pulse -> vectors 000..111 each held 3 cycles; done at edge 24; table_out=8'h96, mismatch_count=0, pass=1.
- Stuck-at-0: EXPECTED=8'h96, f_in=0 -> table_out=8'h00, mismatch_count=4, pass=0, done at edge 24.
- Abort mid-sweep: abort asserted during the SETTLE of vector 3 -> next cycle IDLE, busy=0, {a,b,c}=000, table_out=0, no done. A restart then completes normally with table_out=8'h96.
- Start while busy: extra start pulses at edges 5 and 10 -> no restart; done still at edge 24 with the same results.
- Async reset mid-sweep: rst_n low between edges, during vector 5 -> outputs reset immediately without waiting for a clock edge; after release, start -> full sweep completes correctly.
- AND function: EXPECTED=8'h80, SETTLE_CYCLES=1, f_in=a&b&c -> done at edge 16, table_out=8'h80, pass=1; back-to-back start on the cycle after done is accepted and repeats the result.
